updown_count_ctrl: RTL and testbench

Command-driven controller for the 4-bit up/down counter datapath used on the board display path. It owns the prescaler, direction and run/stop sequencing, and a programmable terminal limit. Commands arrive on a valid/ready port from the front-panel decoder or a host register. The block replaces free-running mode-pin control with a defined state machine and a terminal-count event.

---
 rtl/updown_count_pkg.sv | 30 +++
 rtl/updown_count_ctrl_if.sv | 33 +++
 rtl/updown_prescaler.sv | 34 +++
 rtl/updown_count_ctrl.sv | 168 ++++++++++++++++
 tb/tb_updown_count_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/updown_count_pkg.sv
`default_nettype none
// ============================================================================
// Module      : updown_count_pkg
// Description : Shared opcode/state encodings and width default for the
//               up/down counter controller.
// Revision    : 1.0  initial release
// ============================================================================
package updown_count_pkg;

  localparam int unsigned c_width_dflt = 4;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_LOAD      = 3'd1,
    OP_RUN_UP    = 3'd2,
    OP_RUN_DOWN  = 3'd3,
    OP_STOP      = 3'd4,
    OP_STEP_UP   = 3'd5,
    OP_STEP_DOWN = 3'd6,
    OP_SET_LIMIT = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/updown_count_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : updown_count_ctrl_if
// Description : Valid/ready command channel into the counter controller.
// Revision    : 1.0  initial release
// ============================================================================
interface updown_count_ctrl_if
  import updown_count_pkg::*;
#(
  parameter int unsigned WIDTH = c_width_dflt
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/updown_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : updown_prescaler
// Description : Free-running divider; tick is high while the count is all-ones.
// Revision    : 1.0  initial release
// ============================================================================
module updown_prescaler #(
  parameter int unsigned DIV_WIDTH = 25
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  output logic      tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = clear ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = &cnt_q;

endmodule
`default_nettype wire

// File: rtl/updown_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : updown_count_ctrl
// Description : Command-driven up/down counter controller with prescaled run
//               mode, programmable terminal limit and terminal-count pulse.
//               Optional: define UDC_BOUNCE_EN to reverse at limits instead
//               of wrapping.
// Revision    : 1.0  initial release
// ============================================================================
module updown_count_ctrl
  import updown_count_pkg::*;
#(
  parameter int unsigned WIDTH     = c_width_dflt,
  parameter int unsigned DIV_WIDTH = 25
) (
  input  wire logic          clk,
  input  wire logic          rst,
  updown_count_ctrl_if.slave cmd,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               running,
  output logic               tc
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] count_q,   count_d;
  logic [WIDTH-1:0] limit_q,   limit_d;
  logic             dir_q,     dir_d;
  logic             running_q, running_d;
  logic             tc_q,      tc_d;
  logic             ready_q,   ready_d;

  logic w_accept;
  logic w_tick;
  logic w_clear;
  logic w_do_step;
  logic w_step_up;

  updown_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    dir_d     = dir_q;
    tc_d      = 1'b0;
    w_accept  = cmd.cmd_valid & ready_q;
    ready_d   = ~w_accept;
    w_clear   = 1'b0;
    w_do_step = 1'b0;
    w_step_up = dir_q;

    // An accepted command always takes priority over a coincident tick.
    if (w_accept) begin
      case (cmd.cmd_op)
        OP_LOAD: begin
          count_d = (cmd.cmd_data > limit_q) ? limit_q : cmd.cmd_data;
        end
        OP_RUN_UP: begin
          dir_d   = 1'b1;
          state_d = ST_RUN_UP;
          w_clear = 1'b1;
        end
        OP_RUN_DOWN: begin
          dir_d   = 1'b0;
          state_d = ST_RUN_DOWN;
          w_clear = 1'b1;
        end
        OP_STOP: begin
          state_d = ST_IDLE;
        end
        OP_STEP_UP: begin
          dir_d     = 1'b1;
          w_do_step = 1'b1;
          w_step_up = 1'b1;
        end
        OP_STEP_DOWN: begin
          dir_d     = 1'b0;
          w_do_step = 1'b1;
          w_step_up = 1'b0;
        end
        OP_SET_LIMIT: begin
          limit_d = cmd.cmd_data;
          if (count_q > cmd.cmd_data) begin
            count_d = cmd.cmd_data;
          end
        end
        default: begin
        end
      endcase
    end else if (w_tick && (state_q != ST_IDLE)) begin
      w_do_step = 1'b1;
    end

    if (w_do_step) begin
      if (w_step_up) begin
        if (count_q < limit_q) begin
          count_d = count_q + 1'b1;
        end else begin
          tc_d = 1'b1;
`ifdef UDC_BOUNCE_EN
          count_d = (limit_q == '0) ? '0 : limit_q - 1'b1;
          dir_d   = 1'b0;
          if (state_q != ST_IDLE) begin
            state_d = ST_RUN_DOWN;
          end
`else
          count_d = '0;
`endif
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          tc_d = 1'b1;
`ifdef UDC_BOUNCE_EN
          count_d = (limit_q == '0) ? '0 : c_one;
          dir_d   = 1'b1;
          if (state_q != ST_IDLE) begin
            state_d = ST_RUN_UP;
          end
`else
          count_d = limit_q;
`endif
        end
      end
    end

    running_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      limit_q   <= '1;
      dir_q     <= 1'b1;
      running_q <= 1'b0;
      tc_q      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      tc_q      <= tc_d;
      ready_q   <= ready_d;
    end
  end

  assign count         = count_q;
  assign dir           = dir_q;
  assign running       = running_q;
  assign tc            = tc_q;
  assign cmd.cmd_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_count_ctrl
// Description : Directed plus randomized bench with a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_updown_count_ctrl;
  import updown_count_pkg::*;

  localparam int W   = 4;
  localparam int DW  = 2;
  localparam int PER = 1 << DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  updown_count_ctrl_if #(.WIDTH(W)) cmd_if ();

  logic [W-1:0] count;
  logic         dir;
  logic         running;
  logic         tc;

  updown_count_ctrl #(
    .WIDTH     (W),
    .DIV_WIDTH (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd_if),
    .count   (count),
    .dir     (dir),
    .running (running),
    .tc      (tc)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain integers, direction bit, run flag, phase counter.
  int m_count, m_limit, m_phase;
  bit m_dir, m_run, m_ready, m_tc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_count = 0;
    m_limit = (1 << W) - 1;
    m_dir   = 1'b1;
    m_run   = 1'b0;
    m_tc    = 1'b0;
    m_ready = 1'b0;
    m_phase = 0;
  endfunction

  function automatic void m_step(bit up);
`ifdef UDC_BOUNCE_EN
    if (up && m_count == m_limit) begin
      m_count = (m_limit > 0) ? m_limit - 1 : 0;
      m_dir   = 1'b0;
      m_tc    = 1'b1;
    end else if (!up && m_count == 0) begin
      m_count = (m_limit > 0) ? 1 : 0;
      m_dir   = 1'b1;
      m_tc    = 1'b1;
    end else begin
      m_count = up ? m_count + 1 : m_count - 1;
    end
`else
    if (up) begin
      m_tc    = (m_count == m_limit);
      m_count = (m_count + 1) % (m_limit + 1);
    end else begin
      m_tc    = (m_count == 0);
      m_count = m_tc ? m_limit : m_count - 1;
    end
`endif
  endfunction

  function automatic void m_edge(bit r, bit v, int op, int d);
    bit acc, tick;
    if (r) begin
      m_reset();
      return;
    end
    acc     = v && m_ready;
    tick    = (m_phase == PER - 1);
    m_phase = (m_phase + 1) % PER;
    m_tc    = 1'b0;
    m_ready = !acc;
    if (acc) begin
      case (op)
        1: m_count = (d < m_limit) ? d : m_limit;
        2: begin m_dir = 1'b1; m_run = 1'b1; m_phase = 0; end
        3: begin m_dir = 1'b0; m_run = 1'b1; m_phase = 0; end
        4: m_run = 1'b0;
        5: begin m_dir = 1'b1; m_step(1'b1); end
        6: begin m_dir = 1'b0; m_step(1'b0); end
        7: begin m_limit = d; if (m_count > d) m_count = d; end
        default: ;
      endcase
    end else if (tick && m_run) begin
      m_step(m_dir);
    end
  endfunction

  task automatic clk1();
    bit r, v;
    int op, d;
    r  = rst;
    v  = cmd_if.cmd_valid;
    op = int'(cmd_if.cmd_op);
    d  = int'(cmd_if.cmd_data);
    @(posedge clk);
    m_edge(r, v, op, d);
    #1;
    chk("count",   count,            m_count);
    chk("dir",     dir,              m_dir);
    chk("running", running,          m_run);
    chk("tc",      tc,               m_tc);
    chk("ready",   cmd_if.cmd_ready, m_ready);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  task automatic send(input int op, input int d);
    int n = 0;
    while (!cmd_if.cmd_ready && n < 4) begin
      clk1();
      n++;
    end
    if (!cmd_if.cmd_ready) chk("ready_timeout", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = cmd_op_e'(op[2:0]);
    cmd_if.cmd_data  = d[W-1:0];
    clk1();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int saved;
    rst              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_data  = '0;
    m_reset();

    wait_n(3);
    chk("rst_count", count, 0);
    chk("rst_ready", cmd_if.cmd_ready, 0);
    rst = 1'b0;
    clk1();
    chk("ready_after_rst", cmd_if.cmd_ready, 1);

`ifndef UDC_BOUNCE_EN
    // Up run with wrap at the default all-ones limit.
    send(1, 14);
    send(2, 0);
    wait_n(4);
    chk("up_15", count, 15);
    wait_n(4);
    chk("up_wrap_0", count, 0);
    chk("up_wrap_tc", tc, 1);
    clk1();
    chk("tc_one_cycle", tc, 0);

    // Down run under a reduced limit, then stop and hold.
    send(7, 5);
    send(1, 9);
    chk("load_clamp", count, 5);
    send(3, 0);
    wait_n(20);
    chk("down_0", count, 0);
    wait_n(4);
    chk("down_wrap_5", count, 5);
    chk("down_wrap_tc", tc, 1);
    send(4, 0);
    saved = m_count;
    wait_n(20);
    chk("stop_hold", count, saved);
    chk("stop_running", running, 0);

    // Command colliding with a tick: the tick is discarded.
    send(7, 15);
    send(1, 3);
    send(2, 0);
    wait_n(3);
    send(5, 0);
    chk("collision", count, 4);

    // Limit shrink while running.
    send(1, 12);
    send(2, 0);
    send(7, 7);
    chk("shrink_clamp", count, 7);
    wait_n(2);
    chk("shrink_wrap", count, 0);
    chk("shrink_tc", tc, 1);
    send(4, 0);
`else
    // Reversal at limit 3 starting from 2.
    send(7, 3);
    send(1, 2);
    send(2, 0);
    wait_n(4);
    chk("bnc_3", count, 3);
    wait_n(4);
    chk("bnc_2", count, 2);
    chk("bnc_dir0", dir, 0);
    chk("bnc_tc0", tc, 1);
    wait_n(8);
    chk("bnc_0", count, 0);
    wait_n(4);
    chk("bnc_1", count, 1);
    chk("bnc_dir1", dir, 1);
    chk("bnc_tc1", tc, 1);
    wait_n(2);
    rst = 1'b1;
    clk1();
    chk("bnc_rst_count", count, 0);
    chk("bnc_rst_running", running, 0);
    rst = 1'b0;
    clk1();
`endif

    // Randomized traffic, including occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      rst              = ($urandom_range(0, 99) == 0);
      cmd_if.cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_if.cmd_op    = cmd_op_e'($urandom_range(0, 7));
      cmd_if.cmd_data  = W'($urandom_range(0, (1 << W) - 1));
      clk1();
    end
    rst              = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    clk1();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
